// File: rtl/dht_sensor_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | dht_sensor_ctrl: single-wire DHT11/DHT22 reader with request/valid    |
// | handshake, checksum check, per-phase timeouts and inter-read holdoff. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module dht_sensor_ctrl #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int START_LOW11_US = 18000,
    parameter int START_LOW22_US = 1100,
    parameter int BIT_THRESH_US  = 50,
    parameter int TIMEOUT_US     = 200,
    parameter int HOLDOFF_US     = 1_000_000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic        MODE,
    inout  wire         DHT_DATA,
    output logic        BUSY,
    output logic        VALID,
    output logic [1:0]  ERR,
    output logic [15:0] HUM,
    output logic [15:0] TEMP,
    output logic [39:0] RAW
);

    localparam int c_DIV   = (CLK_HZ / 1_000_000 > 0) ? CLK_HZ / 1_000_000 : 1;
    localparam int c_PRE_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(c_DIV - 1);
    // Restarting the prescaler one step in cancels the one-cycle FSM reaction
    // latency, so a pulse of N us reads as exactly N.
    localparam logic [c_PRE_W-1:0] c_PRE_INIT = (c_DIV > 1) ? c_PRE_W'(1) : '0;
    localparam logic [19:0] c_LOW11   = 20'(START_LOW11_US);
    localparam logic [19:0] c_LOW22   = 20'(START_LOW22_US);
    localparam logic [19:0] c_THRESH  = 20'(BIT_THRESH_US);
    localparam logic [19:0] c_TIMEOUT = 20'(TIMEOUT_US);
    localparam logic [19:0] c_HOLDOFF = 20'(HOLDOFF_US);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_START_LOW = 4'd1,
        S_RELEASE   = 4'd2,
        S_RESP_LOW  = 4'd3,
        S_RESP_HIGH = 4'd4,
        S_BIT_LOW   = 4'd5,
        S_BIT_HIGH  = 4'd6,
        S_CHECK     = 4'd7,
        S_DONE      = 4'd8,
        S_HOLDOFF   = 4'd9
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [1:0]           r_sync;
    logic [c_PRE_W-1:0]   r_pre;
    logic [19:0]          r_cnt;
    logic                 r_mode;
    logic                 r_armed;
    logic [5:0]           r_bits;
    logic [39:0]          r_shift;
    logic [1:0]           r_err;
    logic [15:0]          r_hum;
    logic [15:0]          r_temp;
    logic [39:0]          r_raw;

    logic        w_line;
    logic        w_chg;
    logic        w_shift_en;
    logic        w_fail;
    logic [1:0]  w_fail_code;
    logic [7:0]  w_sum;
    logic [15:0] w_mag;
    logic [15:0] w_temp22;
    logic [15:0] w_hum_dec;
    logic [15:0] w_temp_dec;

    assign w_line   = r_sync[1];
    assign w_chg    = (w_next != r_state);
    assign DHT_DATA = (r_state == S_START_LOW) ? 1'b0 : 1'bz;

    assign w_sum      = r_shift[39:32] + r_shift[31:24] + r_shift[23:16] + r_shift[15:8];
    assign w_mag      = {1'b0, r_shift[22:16], r_shift[15:8]};
    assign w_temp22   = r_shift[23] ? (16'd0 - w_mag) : w_mag;
    assign w_hum_dec  = r_mode ? r_shift[39:24] : {8'd0, r_shift[39:32]};
    assign w_temp_dec = r_mode ? w_temp22 : {8'd0, r_shift[23:16]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_sync  <= 2'b11;
        end else begin
            r_state <= w_next;
            r_sync  <= {r_sync[0], DHT_DATA};
        end
    end

    always_comb begin
        w_next      = r_state;
        w_shift_en  = 1'b0;
        w_fail      = 1'b0;
        w_fail_code = 2'd0;
        case (r_state)
            S_IDLE:      if (REQ) w_next = S_START_LOW;
            S_START_LOW: if (r_cnt >= (r_mode ? c_LOW22 : c_LOW11)) w_next = S_RELEASE;
            S_RELEASE: begin
                // Only a low seen after the line has floated high is a response.
                if (r_cnt > c_TIMEOUT) begin
                    w_fail = 1'b1; w_fail_code = 2'd1;
                end else if (r_armed && !w_line) w_next = S_RESP_LOW;
            end
            S_RESP_LOW: begin
                if (r_cnt > c_TIMEOUT) begin
                    w_fail = 1'b1; w_fail_code = 2'd1;
                end else if (w_line) w_next = S_RESP_HIGH;
            end
            S_RESP_HIGH: begin
                if (r_cnt > c_TIMEOUT) begin
                    w_fail = 1'b1; w_fail_code = 2'd1;
                end else if (!w_line) w_next = S_BIT_LOW;
            end
            S_BIT_LOW: begin
                if (r_cnt > c_TIMEOUT) begin
                    w_fail = 1'b1; w_fail_code = 2'd2;
                end else if (w_line) w_next = S_BIT_HIGH;
            end
            S_BIT_HIGH: begin
                if (r_cnt > c_TIMEOUT) begin
                    w_fail = 1'b1; w_fail_code = 2'd2;
                end else if (!w_line) begin
                    w_shift_en = 1'b1;
                    w_next     = (r_bits == 6'd39) ? S_CHECK : S_BIT_LOW;
                end
            end
            S_CHECK:   w_next = S_DONE;
            S_DONE:    w_next = S_HOLDOFF;
            S_HOLDOFF: if (r_cnt >= c_HOLDOFF) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        if (w_fail) w_next = S_DONE;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else if (w_chg) begin
            r_pre <= c_PRE_INIT;
            r_cnt <= '0;
        end else if (r_pre == c_PRE_LAST) begin
            r_pre <= '0;
            if (r_cnt != 20'hFFFFF) r_cnt <= r_cnt + 20'd1;
        end else begin
            r_pre <= r_pre + c_PRE_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_mode  <= 1'b0;
            r_armed <= 1'b0;
            r_bits  <= '0;
            r_shift <= '0;
            r_err   <= '0;
            r_hum   <= '0;
            r_temp  <= '0;
            r_raw   <= '0;
        end else begin
            if (r_state == S_IDLE && REQ) begin
                r_mode  <= MODE;
                r_bits  <= '0;
                r_shift <= '0;
            end
            if (w_chg)                             r_armed <= 1'b0;
            else if (r_state == S_RELEASE && w_line) r_armed <= 1'b1;
            if (w_shift_en) begin
                r_shift <= {r_shift[38:0], (r_cnt > c_THRESH)};
                r_bits  <= r_bits + 6'd1;
            end
            if (w_fail) r_err <= w_fail_code;
            if (r_state == S_CHECK) begin
                if (w_sum == r_shift[7:0]) begin
                    r_err  <= 2'd0;
                    r_hum  <= w_hum_dec;
                    r_temp <= w_temp_dec;
                    r_raw  <= r_shift;
                end else begin
                    r_err  <= 2'd3;
                end
            end
        end
    end

    assign BUSY  = (r_state != S_IDLE);
    assign VALID = (r_state == S_DONE);
    assign ERR   = r_err;
    assign HUM   = r_hum;
    assign TEMP  = r_temp;
    assign RAW   = r_raw;

endmodule
`default_nettype wire

// File: tb/tb_dht_sensor_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dht_sensor_ctrl: directed and randomized frames from a sensor      |
// | model, checked against an arithmetic decode of each frame.           |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_dht_sensor_ctrl;

    localparam int CLK_HZ     = 2_000_000;
    localparam int HOLDOFF_US = 100;
    localparam int THRESH     = 50;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ = 1'b0;
    logic        MODE = 1'b0;
    logic        sens_low = 1'b0;
    wire         dht_line;
    logic        BUSY, VALID;
    logic [1:0]  ERR;
    logic [15:0] HUM, TEMP;
    logic [39:0] RAW;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_hum  = '0;
    logic [15:0] exp_temp = '0;
    logic [39:0] exp_raw  = '0;

    pullup (dht_line);
    assign dht_line = sens_low ? 1'b0 : 1'bz;

    dht_sensor_ctrl #(
        .CLK_HZ(CLK_HZ), .START_LOW11_US(18000), .START_LOW22_US(1100),
        .BIT_THRESH_US(THRESH), .TIMEOUT_US(200), .HOLDOFF_US(HOLDOFF_US)
    ) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .MODE(MODE), .DHT_DATA(dht_line),
        .BUSY(BUSY), .VALID(VALID), .ERR(ERR), .HUM(HUM), .TEMP(TEMP), .RAW(RAW)
    );

    always #250 CLK = ~CLK;

    initial begin
        #80_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic us(input int n);
        tick(2 * n);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
        n_checks++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Reference decode of a frame, straight from the byte-level rules.
    function automatic void model(input bit mode, input logic [7:0] fb[5],
                                  output logic [15:0] hum, output logic [15:0] temp,
                                  output bit sum_ok, output logic [39:0] raw);
        int sum, mag;
        sum    = (int'(fb[0]) + int'(fb[1]) + int'(fb[2]) + int'(fb[3])) % 256;
        sum_ok = (sum == int'(fb[4]));
        if (!mode) begin
            hum  = 16'(int'(fb[0]));
            temp = 16'(int'(fb[2]));
        end else begin
            hum  = 16'(int'(fb[0]) * 256 + int'(fb[1]));
            mag  = (int'(fb[2]) % 128) * 256 + int'(fb[3]);
            temp = (int'(fb[2]) >= 128) ? 16'(65536 - mag) : 16'(mag);
        end
        raw = '0;
        for (int i = 0; i < 5; i++) raw = (raw << 8) | 40'(fb[i]);
    endfunction

    task automatic sensor_frame(input logic [7:0] fb[5], input int stuck_bit,
                                input bit boundary, output int low_us);
        int n;
        n = 0;
        while (dht_line !== 1'b0 && n < 20) begin tick(1); n++; end
        n = 0;
        while (dht_line === 1'b0 && n < 40000) begin tick(1); n++; end
        low_us = n / 2;
        us(20); sens_low = 1'b1; us(40); sens_low = 1'b0; us(40);
        for (int i = 0; i < 40; i++) begin
            logic b;
            b = fb[i / 8][7 - (i % 8)];
            sens_low = 1'b1; us(15); sens_low = 1'b0;
            if (i == stuck_bit) return;
            if (boundary) us(b ? THRESH + 1 : THRESH);
            else          us(b ? int'($urandom_range(75, 55)) : int'($urandom_range(30, 10)));
        end
        sens_low = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int limit, output int cyc);
        cyc = 0;
        while (VALID !== 1'b1 && cyc < limit) begin tick(1); cyc++; end
        check({tag, "_valid"}, VALID, 1);
    endtask

    task automatic wait_idle(input string tag, input int limit, output int cyc);
        cyc = 0;
        while (BUSY !== 1'b0 && cyc < limit) begin tick(1); cyc++; end
        check({tag, "_busy_off"}, BUSY, 0);
    endtask

    task automatic run_frame(input string tag, input bit mode, input logic [7:0] fb[5],
                             input int stuck_bit, input bit boundary, input int low_exp);
        logic [15:0] h, t;
        logic [39:0] raw;
        logic [1:0]  e;
        bit          ok;
        int          low_us, cyc;
        MODE = mode; REQ = 1'b1; tick(1); REQ = 1'b0; MODE = !mode;
        check({tag, "_busy_on"}, BUSY, 1);
        sensor_frame(fb, stuck_bit, boundary, low_us);
        check_rng({tag, "_start_low_us"}, low_us, low_exp - 1, low_exp + 1);
        model(mode, fb, h, t, ok, raw);
        if (stuck_bit >= 0) e = 2'd2;
        else if (!ok)       e = 2'd3;
        else begin
            e = 2'd0; exp_hum = h; exp_temp = t; exp_raw = raw;
        end
        wait_valid(tag, 2000, cyc);
        check({tag, "_err"},  ERR,  e);
        check({tag, "_hum"},  HUM,  exp_hum);
        check({tag, "_temp"}, TEMP, exp_temp);
        check({tag, "_raw"},  RAW,  exp_raw);
        if (stuck_bit >= 0) check({tag, "_line_released"}, dht_line, 1);
        tick(1);
        check({tag, "_valid_one_cycle"}, VALID, 0);
        sens_low = 1'b0;
    endtask

    initial begin
        logic [7:0] fb[5];
        int cyc, n, lows, busy_seen;

        RST = 1'b1; tick(5);
        check("rst_busy", BUSY, 0);
        check("rst_valid", VALID, 0);
        check("rst_err", ERR, 0);
        check("rst_hum", HUM, 0);
        check("rst_temp", TEMP, 0);
        check("rst_raw", RAW, 0);
        check("rst_line", dht_line, 1);
        RST = 1'b0; tick(2);

        fb = '{8'h37, 8'h00, 8'h19, 8'h00, 8'h50};
        run_frame("dht11", 1'b0, fb, -1, 1'b0, 18000);
        check("dht11_hum_const", HUM, 16'h0037);
        check("dht11_temp_const", TEMP, 16'h0019);
        wait_idle("dht11", 400, cyc);

        fb = '{8'h02, 8'h8C, 8'h80, 8'h65, 8'h73};
        run_frame("dht22neg", 1'b1, fb, -1, 1'b0, 1100);
        check("dht22neg_hum_const", HUM, 16'h028C);
        check("dht22neg_temp_const", TEMP, 16'hFF9B);
        wait_idle("dht22neg", 400, cyc);

        fb = '{8'h37, 8'h00, 8'h19, 8'h00, 8'h51};
        run_frame("cksum", 1'b1, fb, -1, 1'b0, 1100);
        check("cksum_err_const", ERR, 2'd3);
        wait_idle("cksum", 400, cyc);

        // No sensor: only the pull-up ever drives the line.
        MODE = 1'b1; REQ = 1'b1; tick(1); REQ = 1'b0;
        n = 0;
        while (dht_line === 1'b0 && n < 4000) begin tick(1); n++; end
        check_rng("nosensor_start_low_us", n / 2, 1099, 1101);
        wait_valid("nosensor", 1000, cyc);
        check_rng("nosensor_valid_cycles", cyc, 400, 404);
        check("nosensor_err", ERR, 2'd1);
        check("nosensor_hum", HUM, exp_hum);
        tick(1);
        check("nosensor_valid_one_cycle", VALID, 0);
        wait_idle("nosensor", 400, cyc);
        check_rng("nosensor_holdoff_cycles", cyc, 198, 202);

        fb = '{8'h41, 8'h22, 8'h13, 8'h77, 8'hED};
        run_frame("stuck", 1'b1, fb, 20, 1'b0, 1100);
        REQ = 1'b1; tick(1); REQ = 1'b0;
        n = 0; lows = 0;
        while (BUSY !== 1'b0 && n < 400) begin
            if (dht_line === 1'b0) lows++;
            tick(1); n++;
        end
        check("stuck_busy_off", BUSY, 0);
        check_rng("stuck_holdoff_cycles", n, 197, 201);
        busy_seen = 0;
        repeat (20) begin
            tick(1);
            if (dht_line === 1'b0) lows++;
            if (BUSY === 1'b1) busy_seen++;
        end
        check("stuck_req_ignored_lows", lows, 0);
        check("stuck_req_not_queued", busy_seen, 0);

        MODE = 1'b1; REQ = 1'b1; tick(1); REQ = 1'b0;
        tick(100);
        check("rstmid_line_low", dht_line, 0);
        RST = 1'b1; tick(1);
        check("rstmid_line", dht_line, 1);
        check("rstmid_busy", BUSY, 0);
        check("rstmid_valid", VALID, 0);
        check("rstmid_err", ERR, 0);
        check("rstmid_hum", HUM, 0);
        check("rstmid_temp", TEMP, 0);
        check("rstmid_raw", RAW, 0);
        exp_hum = '0; exp_temp = '0; exp_raw = '0;
        RST = 1'b0; tick(2);

        // Random frame with high pulses sitting exactly on the threshold edge.
        for (int i = 0; i < 4; i++) fb[i] = 8'($urandom);
        fb[4] = 8'((int'(fb[0]) + int'(fb[1]) + int'(fb[2]) + int'(fb[3])) % 256);
        run_frame("fresh", 1'b1, fb, -1, 1'b1, 1100);
        wait_idle("fresh", 400, cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
